// File: rtl/doorlock_ctrl.sv
// doorlock_ctrl: keypad code-entry controller.
// Collects CODE_LEN digits from single-cycle key pulses, checks them against
// PASSWORD on ENTER, then runs the unlock, wrong-code or lockout window.
// Outputs are Moore, decoded from the registered state.

module doorlock_ctrl #(
  parameter int unsigned             CODE_LEN    = 4,
  parameter logic [3*CODE_LEN-1:0]   PASSWORD    = 12'o1234,
  parameter int unsigned             OPEN_CYCLES = 50000000,
  parameter int unsigned             FAIL_CYCLES = 25000000,
  parameter int unsigned             LOCK_CYCLES = 500000000,
  parameter int unsigned             MAX_FAIL    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key_pulse,
  output logic       unlock,
  output logic       err,
  output logic       locked_out,
  output logic [2:0] digit_cnt,
  output logic [1:0] fail_cnt,
  output logic [2:0] state_o
);

  // Buffer width: 3 bits per digit, first digit ends up in the MSBs.
  localparam int unsigned BW = 3 * CODE_LEN;

  // The timer only has to hold the largest reload value (N-1).
  localparam int unsigned MAX_OF_OF = (OPEN_CYCLES > FAIL_CYCLES) ? OPEN_CYCLES : FAIL_CYCLES;
  localparam int unsigned MAX_CYC   = (MAX_OF_OF > LOCK_CYCLES) ? MAX_OF_OF : LOCK_CYCLES;
  localparam int unsigned TW        = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] FAIL_LOAD = TW'(FAIL_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);

  localparam logic [2:0] LEN_FULL = 3'(CODE_LEN);
  localparam logic [2:0] FAIL_MAX = 3'(MAX_FAIL);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    FAIL    = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  state_t          state, state_d;
  logic [BW-1:0]   buffer, buffer_d;
  logic [2:0]      digit_cnt_d;
  logic [1:0]      fail_cnt_d;
  logic [TW-1:0]   timer, timer_d;

  logic            key_valid;
  logic [2:0]      key_idx;
  logic            is_digit;
  logic            is_enter;
  logic            is_clear;
  logic            code_match;
  logic [2:0]      fail_next;

  // Key decode: a key counts only when exactly one bit is set; key_idx is its position.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first,
    // otherwise a path that skips the assignment infers a latch.
    key_idx   = '0;
    key_valid = (key_pulse != '0) && ((key_pulse & (key_pulse - 8'd1)) == '0);
    for (int i = 0; i < 8; i++) begin
      if (key_pulse[i]) key_idx = 3'(i);
    end
  end

  assign is_digit = key_valid && !key_pulse[7] && !key_pulse[6];
  assign is_enter = key_valid && key_pulse[6];
  assign is_clear = key_valid && key_pulse[7];

  // A short code never matches, even if the stored bits happen to equal PASSWORD.
  assign code_match = (digit_cnt == LEN_FULL) && (buffer == PASSWORD);
  assign fail_next  = {1'b0, fail_cnt} + 3'd1;

  // Next-state and datapath update for every state.
  always_comb begin
    state_d     = state;
    buffer_d    = buffer;
    digit_cnt_d = digit_cnt;
    fail_cnt_d  = fail_cnt;
    timer_d     = timer;

    unique case (state)
      IDLE: begin
        if (is_digit) begin
          buffer_d    = (buffer << 3) | BW'(key_idx);
          digit_cnt_d = 3'd1;
          state_d     = ENTRY;
        end
      end

      ENTRY: begin
        if (is_digit) begin
          // Digits beyond CODE_LEN are dropped rather than shifting the code out.
          if (digit_cnt < LEN_FULL) begin
            buffer_d    = (buffer << 3) | BW'(key_idx);
            digit_cnt_d = digit_cnt + 3'd1;
          end
        end else if (is_clear) begin
          buffer_d    = '0;
          digit_cnt_d = '0;
          state_d     = IDLE;
        end else if (is_enter) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        buffer_d    = '0;
        digit_cnt_d = '0;
        if (code_match) begin
          fail_cnt_d = '0;
          timer_d    = OPEN_LOAD;
          state_d    = OPEN;
        end else if (fail_next == FAIL_MAX) begin
          fail_cnt_d = FAIL_MAX[1:0];
          timer_d    = LOCK_LOAD;
          state_d    = LOCKOUT;
        end else begin
          fail_cnt_d = fail_next[1:0];
          timer_d    = FAIL_LOAD;
          state_d    = FAIL;
        end
      end

      OPEN, FAIL, LOCKOUT: begin
        // Timer is loaded with N-1 and the exit happens on 0, giving exactly N cycles.
        if ((timer == '0) || (state == OPEN && is_clear)) begin
          timer_d = '0;
          state_d = IDLE;
          if (state == LOCKOUT) fail_cnt_d = '0;
        end else begin
          timer_d = timer - 1'b1;
        end
      end

      default: begin
        buffer_d    = '0;
        digit_cnt_d = '0;
        fail_cnt_d  = '0;
        timer_d     = '0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      buffer    <= '0;
      digit_cnt <= '0;
      fail_cnt  <= '0;
      timer     <= '0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // the pre-edge values, independent of statement order.
      state     <= state_d;
      buffer    <= buffer_d;
      digit_cnt <= digit_cnt_d;
      fail_cnt  <= fail_cnt_d;
      timer     <= timer_d;
    end
  end

  assign unlock     = (state == OPEN);
  assign err        = (state == FAIL);
  assign locked_out = (state == LOCKOUT);
  assign state_o    = state;

endmodule
